// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: reusable handshaked pipeline stage register.
//
// Holds an opaque DATA_W-bit payload between a producer and a consumer.
// Supports a synchronous flush, a saturating stall counter and an
// occupancy output for hazard debugging and performance monitoring.
//
// Build option: define PIPE_SKID_EN to add a second (skid) register.
// With it, in_ready comes straight from a flop and the stage holds up to
// two payloads. Without it, this is a single-register stage whose
// in_ready is combinational.
//
// Handshake: a transfer happens on a rising edge where valid && ready
// are both high. A producer keeps valid and data stable until that
// transfer. Ready may depend on state, but never on the partner's
// valid in the same cycle.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
`ifdef PIPE_SKID_EN
  localparam logic [1:0] ST_TWO   = 2'd2;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic              in_fire;
  logic              out_fire;

`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_d;
  logic              in_ready_q;
`endif

  // The state encoding doubles as the payload count.
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign dbg_state = state_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

`ifdef PIPE_SKID_EN
  assign in_ready = in_ready_q;
`else
  assign in_ready = !out_valid || out_ready;
`endif

  // Next state and register loads. Flush wins over all other activity.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
`ifdef PIPE_SKID_EN
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = ST_TWO;
`endif
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
`ifdef PIPE_SKID_EN
        ST_TWO: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

`ifdef PIPE_SKID_EN
  // Skid register and registered in_ready, which looks one state ahead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      skid_q     <= skid_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end
`endif

  // Saturating count of cycles where the consumer holds us off.
  // Flush does not clear it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and scoreboard checks for pipe_stage_reg.
// Works with or without PIPE_SKID_EN; skid-only scenarios are guarded.
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [CNT_W-1:0]  exp_stall;
  logic              stall_pend = 1'b0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Inputs change only just after posedge, so the negedge sees the
  // values that the next posedge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      stall_pend = 1'b0;
    end else begin
      stall_pend = out_valid && !out_ready;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
        else check("sb_data", out_data, exp_q.pop_front());
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  // Reference stall counter, advanced on the same edge as the DUT's.
  always @(posedge clk or negedge rst) begin
    if (!rst) exp_stall = '0;
    else if (stall_pend && exp_stall != CNT_MAX) exp_stall = exp_stall + 1'b1;
  end

  // ---------------- driver tasks ----------------
  // Called just after a posedge; returns just after the capturing posedge.
  task automatic push_one(input logic [DATA_W-1:0] d);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (!out_valid) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
    check("sb_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [DATA_W-1:0] vals [3];

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

    // Reset holds everything cleared despite random inputs.
    repeat (4) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      flush     = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_occupancy", occupancy, 0);
      check("rst_stall_cnt", stall_cnt, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; rst = 1'b1;

    // First payload after reset, visible one cycle after acceptance.
    push_one(32'h11);
    @(negedge clk);
    check("first_out_valid", out_valid, 1);
    check("first_out_data", out_data, 32'h11);
    @(posedge clk); #1;

    // Back-to-back streaming, no bubbles.
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = vals[i];
      @(negedge clk);
      check("stream_in_ready", in_ready, 1);
      if (i > 0) begin
        check("stream_out_valid", out_valid, 1);
        check("stream_out_data", out_data, vals[i-1]);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_last_valid", out_valid, 1);
    check("stream_last_data", out_data, vals[2]);
    check("stream_stall_cnt", stall_cnt, 0);
    @(posedge clk); #1;
    drain();

`ifdef PIPE_SKID_EN
    // Backpressure fills both registers; C waits at the source.
    out_ready = 1'b0;
    push_one(32'hA);
    push_one(32'hB);
    @(negedge clk);
    check("bp_occupancy", occupancy, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_data", out_data, 32'hA);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'hC;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    push_one(32'hC);
    drain();
    check("bp_stall_cnt", stall_cnt, exp_stall);
`else
    // Single register: in_ready follows out_ready within the cycle.
    out_ready = 1'b0;
    push_one(32'hA);
    in_valid = 1'b1; in_data = 32'hB;
    @(negedge clk);
    check("nsk_in_ready_lo", in_ready, 0);
    check("nsk_occupancy", occupancy, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    check("nsk_in_ready_hi", in_ready, 1);
    @(negedge clk);
    check("nsk_occupancy_max", occupancy, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    check("nsk_stall_cnt", stall_cnt, exp_stall);
`endif

    // Flush with a payload offered in the same cycle; it must vanish.
    out_ready = 1'b0;
    push_one(32'h44);
`ifdef PIPE_SKID_EN
    push_one(32'h45);
`endif
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_occupancy", occupancy, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_state", dbg_state, 0);
    check("flush_stall_cnt", stall_cnt, exp_stall);
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_one(32'h55);
    drain();

    // Stall counter saturation, unaffected by flush.
    rst = 1'b0;
    @(negedge clk);
    check("sat_rst_stall", stall_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b0;
    push_one(32'h66);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("sat_stall_15", stall_cnt, 15);
    check("sat_stall_model", stall_cnt, exp_stall);
    check("sat_hold_data", out_data, 32'h66);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sat_stall_stays", stall_cnt, 15);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("sat_after_flush", stall_cnt, 15);
    check("sat_flush_valid", out_valid, 0);
    @(posedge clk); #1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
